// File: rtl/psum_acc_pkg.sv
// Shared definitions for the psum accumulator sequencer.
//   - Bit positions of the 32-bit info sideband that travels with each beat.
//   - State encoding of the sequencer FSM.
package psum_acc_pkg;

  localparam int unsigned INFO_ADDR_MSB = 11;
  localparam int unsigned INFO_ACC_BIT  = 12;
  localparam int unsigned INFO_ID_BIT   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    ACC   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/psum_acc_sched_if.sv
// Beat stream bundle between the MAC array, the sequencer and the psum
// accumulator.
//   mac_in_*  : MAC array beat stream into the sequencer
//   acc_out_* : beat stream plus info sideband toward the accumulator
//   merge_*   : snoop of the accumulator output handshake
// Modports:
//   slave  : sequencer side
//   master : environment side (MAC array, accumulator)
interface psum_acc_sched_if;
  logic [63:0] mac_in_data;
  logic        mac_in_vld;
  logic        mac_in_rdy;
  logic [63:0] acc_out_data;
  logic [31:0] acc_out_info;
  logic        acc_out_vld;
  logic        acc_out_rdy;
  logic        merge_vld;
  logic        merge_rdy;

  modport slave (
    input  mac_in_data, mac_in_vld, acc_out_rdy, merge_vld, merge_rdy,
    output mac_in_rdy, acc_out_data, acc_out_info, acc_out_vld
  );

  modport master (
    output mac_in_data, mac_in_vld, acc_out_rdy, merge_vld, merge_rdy,
    input  mac_in_rdy, acc_out_data, acc_out_info, acc_out_vld
  );
endinterface

// File: rtl/psum_acc_sched_cnt.sv
// Wrap-around address / tile counter pair for the psum sequencer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear of both counters
//   inc          : one accepted beat
//   tile_en      : allow the tile counter to advance on an address wrap
//   pix_num      : last address of a pass
//   tile_num     : last tile of a job
//   addr         : current buffer address
//   addr_last    : addr == pix_num
//   tile_last    : tile == tile_num
module psum_acc_sched_cnt #(
  parameter int unsigned AW = 12,
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          tile_en,
  input  logic [AW-1:0] pix_num,
  input  logic [TW-1:0] tile_num,
  output logic [AW-1:0] addr,
  output logic          addr_last,
  output logic          tile_last
);

  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] tile_q, tile_d;

  assign addr      = addr_q;
  assign addr_last = (addr_q == pix_num);
  assign tile_last = (tile_q == tile_num);

  always_comb begin
    addr_d = addr_q;
    tile_d = tile_q;
    if (clr) begin
      addr_d = '0;
      tile_d = '0;
    end else if (inc) begin
      if (addr_last) begin
        addr_d = '0;
        if (tile_en && !tile_last) begin
          tile_d = tile_q + TW'(1);
        end
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      tile_q <= '0;
    end else begin
      addr_q <= addr_d;
      tile_q <= tile_d;
    end
  end

endmodule

// File: rtl/psum_acc_sched.sv
// Sequencer between the MAC array output stream and the psum accumulator.
// Runs a job of cfg_tile_num+1 tiles, each a write pass then an accumulate
// pass over cfg_pix_num+1 addresses, and tags each beat with an info word:
//   info[11:0] address, info[12] accumulate pass, info[13] identity select.
// Completion is detected by counting accumulator output handshakes.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_start         : start pulse, config sampled in the same cycle (IDLE only)
//   cfg_pix_num       : pixels per tile minus 1
//   cfg_tile_num      : tiles per job minus 1
//   cfg_identity_en   : identity select for accumulate passes
//   sched_busy        : job in progress
//   sched_done        : one-cycle completion pulse
//   bus               : beat streams and merge snoop (psum_acc_sched_if.slave)
//   perf_stall_cnt    : output stall cycles
// Build option: PSUM_ACC_SCHED_PERF_EN enables the stall counter; otherwise
// perf_stall_cnt is tied to zero.
module psum_acc_sched
  import psum_acc_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned TW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [AW-1:0]        cfg_pix_num,
  input  logic [TW-1:0]        cfg_tile_num,
  input  logic                 cfg_identity_en,
  output logic                 sched_busy,
  output logic                 sched_done,
  psum_acc_sched_if.slave      bus,
  output logic [31:0]          perf_stall_cnt
);

  localparam int unsigned CW = AW + TW;

  state_e        state_q, state_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [TW-1:0] tnum_q, tnum_d;
  logic          id_q, id_d;
  logic [CW-1:0] total_q, total_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic          active;
  logic          start;
  logic          beat;
  logic          merge_hs;
  logic [AW-1:0] addr;
  logic          addr_last;
  logic          tile_last;
  logic [31:0]   info;

  assign active   = (state_q == WR) || (state_q == ACC);
  assign start    = cfg_start && (state_q == IDLE);
  assign beat     = bus.mac_in_vld && bus.acc_out_rdy && active;
  assign merge_hs = bus.merge_vld && bus.merge_rdy && (state_q != IDLE);

  assign bus.acc_out_vld  = bus.mac_in_vld && active;
  assign bus.mac_in_rdy   = bus.acc_out_rdy && active;
  assign bus.acc_out_data = bus.mac_in_data;
  assign bus.acc_out_info = info;

  // Built only from flops, so it cannot change while a beat is held off.
  always_comb begin
    info              = '0;
    info[AW-1:0]      = active ? addr : '0;
    info[INFO_ACC_BIT] = (state_q == ACC);
    info[INFO_ID_BIT]  = (state_q == ACC) && id_q;
  end

  // The output count is registered, so a merge landing together with the
  // last accumulate beat is already visible in the first DRAIN cycle.
  assign sched_done = (state_q == DRAIN) && (out_cnt_q == total_q);
  assign sched_busy = (state_q != IDLE) && !sched_done;

  psum_acc_sched_cnt #(.AW(AW), .TW(TW)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .inc       (beat),
    .tile_en   (state_q == ACC),
    .pix_num   (pix_q),
    .tile_num  (tnum_q),
    .addr      (addr),
    .addr_last (addr_last),
    .tile_last (tile_last)
  );

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    tnum_d    = tnum_q;
    id_d      = id_q;
    total_d   = total_q;
    out_cnt_d = out_cnt_q;
    if (merge_hs) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          pix_d     = cfg_pix_num;
          tnum_d    = cfg_tile_num;
          id_d      = cfg_identity_en;
          total_d   = (CW'(cfg_pix_num) + CW'(1)) * (CW'(cfg_tile_num) + CW'(1));
          out_cnt_d = '0;
          state_d   = WR;
        end
      end
      WR: begin
        if (beat && addr_last) state_d = ACC;
      end
      ACC: begin
        if (beat && addr_last) state_d = tile_last ? DRAIN : WR;
      end
      DRAIN: begin
        if (sched_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      tnum_q    <= '0;
      id_q      <= 1'b0;
      total_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      tnum_q    <= tnum_d;
      id_q      <= id_d;
      total_q   <= total_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef PSUM_ACC_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start) begin
      stall_d = '0;
    end else if (bus.acc_out_vld && !bus.acc_out_rdy && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
